demux64x1_4_buf: RTL and testbench
==================================

// Module: demux64x1_4_buf
// PURPOSE
//  Registered 1-to-4 demultiplexer, the distribution counterpart of the 64-bit 4:1 select mux.
//  - One valid/ready input stream carries a 2-bit lane select.
//  - Each word is steered into a small per-lane FIFO.
//  - Four independent valid/ready output lanes drain the FIFOs.
//  - Sits between a single producer (e.g. writeback/result bus) and four consumers.
// PARAMETERS
//  WIDTH  64  data width of every lane
//  DEPTH  2   entries per lane FIFO; power of two, >= 2
// PORTS
//  clk         in   1         rising-edge clock
//  reset       in   1         synchronous, active-high reset
//  in_valid    in   1         producer has a word
//  in_ready    out  1         block accepts the word this cycle
//  in_sel      in   2         destination lane 0..3
//  in_data     in   WIDTH     input word
//  out_valid   out  4         bit k: lane k FIFO non-empty
//  out_ready   in   4         bit k: consumer k takes head word
//  out_data0   out  WIDTH     lane 0 head word; out_data1..3 likewise for lanes 1..3
//  lane_count  out  4*(log2(DEPTH)+1)  per-lane occupancy; lane k at slice k
// BEHAVIOUR
//  Reset
//  - Held high at a clk edge: all pointers and counts clear, so out_valid=0 and lane_count=0.
//  - All out_dataN read 0, and reset mid-stream discards every stored word.
//  - in_ready is low while reset is high.
//  Input handshake
//  - in_ready = !reset && (count[in_sel] != DEPTH). Purely combinational on in_sel and state.
//  - in_ready does not look at out_ready, so there is no in->out combinational path.
//  - push = in_valid && in_ready. in_data is written at the tail of lane in_sel.
//  - Exactly one lane is pushed per cycle. in_sel, in_data and in_valid must hold until accepted.
//  Output handshake
//  - out_valid[k] = (count[k] != 0).
//  - out_dataN = head entry of lane N, or 0 when that lane is empty.
//  - pop[k] = out_valid[k] && out_ready[k]. out_ready on an empty lane is ignored.
//  Timing
//  - Latency: a word pushed at edge t is visible on out_valid/out_data at t+1 (1 cycle).
//  Per-lane update
//  - push only: count+1, tail+1.
//  - pop only: count-1, head+1.
//  - push and pop together: count unchanged, both pointers advance.
//  - A full lane refuses the push even if it pops the same cycle, so lane k needs one bubble after a full pop.
//  - All four lanes may pop in the same cycle.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//  Ordering
//  - Strict FIFO order within a lane. No ordering between lanes.
//  - A full lane never blocks pushes to other lanes once in_sel changes.
//  Lane state machine (per lane, derived from count)
//  - EMPTY -push-> PARTIAL (or FULL if DEPTH==1; not allowed).
//  - PARTIAL -push&!pop, count==DEPTH-1-> FULL.
//  - PARTIAL -pop&!push, count==1-> EMPTY.
//  - FULL -pop-> PARTIAL.
//  - Any state -reset-> EMPTY.
// TESTING
//  1. Reset, then push 0xA5 to lane 2 -> next cycle out_valid=4'b0100, out_data2=0xA5, lane2 count=1.
//  2. Push 1,2,3 to lane 0 with out_ready=0 -> in_ready drops after 2; out_data0=1, then 2 after one pop.
//  3. Lane 1 full with pop and push in the same cycle -> push refused (in_ready=0), count goes 2->1.
//  4. Lane 3 at count 1: push 7 and pop together -> count stays 1, out_data3=7 next cycle.
//  5. Fill all lanes with 0..7 interleaved, then pop all lanes each cycle -> per-lane order kept, all empty after DEPTH cycles.
//  6. Reset asserted with lanes holding data -> out_valid=0, out_data*=0, in_ready=0 during reset.
//  7. Push 10 words to lane 0, popping every cycle -> pointers wrap, data matches in order, nothing lost.

Source files
------------

// File: rtl/demux64x1_4_buf_if.sv
// ----------------------------------------------------------------------------
// demux64x1_4_buf_if
//   Bundle for the 1-to-4 registered demultiplexer: one valid/ready input
//   stream carrying a 2-bit lane select, and four valid/ready output lanes.
//   Signals
//     in_valid/in_ready/in_sel/in_data : producer -> block
//     out_valid[3:0]/out_ready[3:0]    : per-lane output handshake
//     out_data0..out_data3             : head word of each lane (0 if empty)
//     lane_count                       : per-lane occupancy, lane k at slice k
//   Modports
//     master : producer/consumer side (testbench or surrounding logic)
//     slave  : the demux itself
// ----------------------------------------------------------------------------
interface demux64x1_4_buf_if #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                  in_valid;
   logic                  in_ready;
   logic [1:0]            in_sel;
   logic [WIDTH-1:0]      in_data;
   logic [3:0]            out_valid;
   logic [3:0]            out_ready;
   logic [WIDTH-1:0]      out_data0;
   logic [WIDTH-1:0]      out_data1;
   logic [WIDTH-1:0]      out_data2;
   logic [WIDTH-1:0]      out_data3;
   logic [4*CW-1:0]       lane_count;

   modport master (
      output in_valid, in_sel, in_data, out_ready,
      input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
             lane_count
   );

   modport slave (
      input  in_valid, in_sel, in_data, out_ready,
      output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
             lane_count
   );
endinterface

// File: rtl/demux64x1_4_buf.sv
// ----------------------------------------------------------------------------
// demux64x1_4_buf
//   Registered 1-to-4 demultiplexer. Each accepted input word is written to
//   the tail of the small FIFO selected by in_sel; four independent output
//   lanes drain their FIFOs with their own valid/ready handshakes.
//   Ports
//     clk_i   : rising-edge clock
//     reset_i : synchronous active-high reset (clears all lanes)
//     bus     : demux64x1_4_buf_if.slave (input stream + four output lanes)
// ----------------------------------------------------------------------------

// Per-lane FIFO. Occupancy state (EMPTY/PARTIAL/FULL) is derived from the
// count, so there is no separate state register to keep consistent.
module demux64x1_4_buf_lane #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             full_o,
   output logic [CW-1:0]    count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_PARTIAL = 2'd1;
   localparam logic [1:0] ST_FULL    = 2'd2;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [1:0]       state;

   always_comb begin
      if (count_q == '0)            state = ST_EMPTY;
      else if (count_q == CNT_FULL) state = ST_FULL;
      else                          state = ST_PARTIAL;
   end

   assign valid_o = (state != ST_EMPTY);
   assign full_o  = (state == ST_FULL);
   assign count_o = count_q;
   // Head word is masked so an empty lane presents zero, not stale storage.
   assign data_o  = valid_o ? mem_q[head_q] : '0;

   // Pointers are PW bits wide; DEPTH is a power of two so overflow wraps.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push_i) tail_d = tail_q + PTR_ONE;
      if (pop_i)  head_d = head_q + PTR_ONE;
      if (push_i && !pop_i)      count_d = count_q + CNT_ONE;
      else if (pop_i && !push_i) count_d = count_q - CNT_ONE;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: reads are masked by valid_o.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[tail_q] <= data_i;
   end
endmodule

module demux64x1_4_buf #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                clk_i,
   input  logic                reset_i,
   demux64x1_4_buf_if.slave    bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [3:0]             push;
   logic [3:0]             pop;
   logic [3:0]             full;
   logic [3:0]             valid;
   logic [3:0][WIDTH-1:0]  head_data;
   logic [3:0][CW-1:0]     count;
   logic                   in_ready;

   // Only the selected lane's fullness gates the input; out_ready is not
   // consulted, so there is no combinational input-to-output path and a
   // full lane refuses a push even in a cycle where it pops.
   assign in_ready = !reset_i && !full[bus.in_sel];

   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign push[k] = bus.in_valid && in_ready && (bus.in_sel == 2'(k));
      assign pop[k]  = valid[k] && bus.out_ready[k];

      demux64x1_4_buf_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_lane (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .push_i  (push[k]),
         .pop_i   (pop[k]),
         .data_i  (bus.in_data),
         .data_o  (head_data[k]),
         .valid_o (valid[k]),
         .full_o  (full[k]),
         .count_o (count[k])
      );
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = valid;
   assign bus.out_data0  = head_data[0];
   assign bus.out_data1  = head_data[1];
   assign bus.out_data2  = head_data[2];
   assign bus.out_data3  = head_data[3];
   assign bus.lane_count = count;
endmodule

// File: tb/tb_demux64x1_4_buf.sv
module tb_demux64x1_4_buf;
   localparam int WIDTH = 64;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   logic acc;

   demux64x1_4_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ifc ();

   demux64x1_4_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one queue of words per lane.
   logic [WIDTH-1:0] mq [4][$];

   task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                        input logic [WIDTH-1:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] dut_data(input int k);
      case (k)
         0: return ifc.out_data0;
         1: return ifc.out_data1;
         2: return ifc.out_data2;
         default: return ifc.out_data3;
      endcase
   endfunction

   // One clock cycle: drive inputs, check every output against the model,
   // then apply the cycle's push/pops to the model at the rising edge.
   task automatic cycle(input logic r, input logic v, input logic [1:0] s,
                        input logic [WIDTH-1:0] d, input logic [3:0] ordy);
      logic       exp_rdy;
      logic [3:0] exp_vld;
      rst = r;
      ifc.in_valid = v;
      ifc.in_sel = s;
      ifc.in_data = d;
      ifc.out_ready = ordy;
      #1;
      exp_rdy = !r && (mq[s].size() != DEPTH);
      for (int k = 0; k < 4; k++) exp_vld[k] = (mq[k].size() != 0);
      check("in_ready", {63'd0, ifc.in_ready}, {63'd0, exp_rdy});
      check("out_valid", {60'd0, ifc.out_valid}, {60'd0, exp_vld});
      for (int k = 0; k < 4; k++) begin
         check($sformatf("out_data%0d", k), dut_data(k),
               (mq[k].size() != 0) ? mq[k][0] : '0);
         check($sformatf("lane_count%0d", k),
               WIDTH'(ifc.lane_count[k*CW +: CW]), WIDTH'(mq[k].size()));
      end
      @(posedge clk);
      acc = v && exp_rdy;
      if (r) begin
         for (int k = 0; k < 4; k++) mq[k].delete();
      end else begin
         for (int k = 0; k < 4; k++)
            if (ordy[k] && mq[k].size() != 0) void'(mq[k].pop_front());
         if (acc) mq[s].push_back(d);
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic [3:0] ordy);
      cycle(1'b0, 1'b0, 2'd0, '0, ordy);
   endtask

   initial begin
      logic             pv;
      logic [1:0]       ps;
      logic [WIDTH-1:0] pd;
      tests = 0;
      fails = 0;
      rst = 1'b1;
      ifc.in_valid = 1'b0;
      ifc.in_sel = 2'd0;
      ifc.in_data = '0;
      ifc.out_ready = 4'd0;
      @(negedge clk);
      // Reset and single push to lane 2
      cycle(1'b1, 1'b0, 2'd0, '0, 4'h0);
      cycle(1'b1, 1'b0, 2'd0, '0, 4'h0);
      cycle(1'b0, 1'b1, 2'd2, 64'hA5, 4'h0);
      idle(4'h0);
      check("t1_valid", {60'd0, ifc.out_valid}, 64'h4);
      idle(4'h4);
      // Lane 0 fills, third push refused until a pop frees space
      cycle(1'b0, 1'b1, 2'd0, 64'd1, 4'h0);
      cycle(1'b0, 1'b1, 2'd0, 64'd2, 4'h0);
      cycle(1'b0, 1'b1, 2'd0, 64'd3, 4'h0);
      check("t2_full_rdy", {63'd0, ifc.in_ready}, 64'd0);
      idle(4'h1);
      cycle(1'b0, 1'b1, 2'd0, 64'd3, 4'h0);
      idle(4'h1); idle(4'h1); idle(4'h0);
      // Full lane 1: simultaneous pop and push, push refused
      cycle(1'b0, 1'b1, 2'd1, 64'h10, 4'h0);
      cycle(1'b0, 1'b1, 2'd1, 64'h11, 4'h0);
      cycle(1'b0, 1'b1, 2'd1, 64'h12, 4'h2);
      cycle(1'b0, 1'b1, 2'd1, 64'h12, 4'h0);
      idle(4'h2); idle(4'h2); idle(4'h0);
      // Lane 3 at count 1: push and pop together
      cycle(1'b0, 1'b1, 2'd3, 64'h6, 4'h0);
      cycle(1'b0, 1'b1, 2'd3, 64'h7, 4'h8);
      idle(4'h0);
      check("t4_data3", ifc.out_data3, 64'h7);
      idle(4'h8);
      // Interleaved fill of all lanes, then drain all at once
      for (int i = 0; i < 8; i++)
         cycle(1'b0, 1'b1, 2'(i % 4), 64'(i), 4'h0);
      idle(4'hF); idle(4'hF); idle(4'h0);
      // Reset with stored data, input valid held high
      cycle(1'b0, 1'b1, 2'd0, 64'h55, 4'h0);
      cycle(1'b0, 1'b1, 2'd2, 64'h66, 4'h0);
      cycle(1'b1, 1'b1, 2'd1, 64'h77, 4'h0);
      cycle(1'b1, 1'b1, 2'd1, 64'h77, 4'h0);
      cycle(1'b0, 1'b0, 2'd0, '0, 4'h0);
      // Pointer wrap on lane 0
      for (int i = 0; i < 10; i++)
         cycle(1'b0, 1'b1, 2'd0, 64'(100 + i), 4'h1);
      idle(4'h1); idle(4'h0);
      // Random traffic; a word holds its select/data until accepted
      pv = 1'b0; ps = 2'd0; pd = '0;
      for (int i = 0; i < 400; i++) begin
         if (!pv && ($urandom_range(0, 3) != 0)) begin
            pv = 1'b1;
            ps = 2'($urandom_range(0, 3));
            pd = {$urandom, $urandom};
         end
         cycle(($urandom_range(0, 99) == 0), pv, ps, pd,
               4'($urandom_range(0, 15)));
         if (acc || rst) pv = 1'b0;
      end
      idle(4'hF); idle(4'hF); idle(4'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
